// File: rtl/store_merge.sv
//-----------------------------------------------------------------------------
// store_merge
//   Read-modify-write engine for sub-doubleword stores. A doubleword store
//   (sd) is written straight through; byte/half/word stores (sb/sh/sw) read
//   the aligned doubleword, replace the selected little-endian lane with the
//   low bytes of wdata and write the result back.
//
// Configuration:
//   STORE_MISALIGN_TRAP_EN  when defined, misaligned sh/sw/sd requests skip
//                           the memory access and finish with misalign=1.
//                           When undefined, misalign is always 0 and the
//                           low address bits that do not pick a lane are
//                           ignored.
//
// Ports:
//   clk         single clock, rising edge
//   rst         asynchronous active-low reset
//   start       store request, sampled only while idle
//   store_type  00=sd, 01=sw, 10=sh, 11=sb
//   addr        byte address
//   wdata       store data (low bytes used for partial stores)
//   mem_rdata   memory read data, valid one cycle after mem_addr
//   mem_addr    doubleword-aligned memory address (0 while idle)
//   mem_wdata   merged doubleword to memory
//   mem_wr      memory write enable, one cycle per store
//   busy        high whenever the engine is not idle
//   done        one-cycle completion pulse
//   misalign    misalignment flag, valid with done
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module store_merge (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  store_type,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  localparam logic [1:0] ST_SD = 2'b00;
  localparam logic [1:0] ST_SW = 2'b01;
  localparam logic [1:0] ST_SH = 2'b10;
  localparam logic [1:0] ST_SB = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [63:0] addr_r;
  logic [63:0] addr_nxt_s;
  logic [63:0] wdata_r;
  logic [63:0] wdata_nxt_s;
  logic [1:0]  type_r;
  logic [1:0]  type_nxt_s;
  logic [63:0] mem_addr_r;
  logic [63:0] mem_addr_nxt_s;
  logic [63:0] mem_wdata_r;
  logic [63:0] mem_wdata_nxt_s;
  logic        mem_wr_r;
  logic        busy_r;
  logic        done_r;
  logic        misalign_r;
  logic        misalign_nxt_s;
  logic        trap_s;

  // Replace the lane selected by type/low address bits; everything else
  // keeps the value read from memory. Address bits below the lane size
  // simply do not take part in the shift amount.
  function automatic logic [63:0] merge_lane(
    input logic [63:0] old_dw,
    input logic [63:0] new_data,
    input logic [1:0]  st,
    input logic [2:0]  lo
  );
    logic [63:0] mask;
    logic [63:0] data;
    case (st)
      ST_SB: begin
        mask = 64'h0000_0000_0000_00FF << {lo, 3'b000};
        data = {56'h0, new_data[7:0]} << {lo, 3'b000};
      end
      ST_SH: begin
        mask = 64'h0000_0000_0000_FFFF << {lo[2:1], 4'b0000};
        data = {48'h0, new_data[15:0]} << {lo[2:1], 4'b0000};
      end
      ST_SW: begin
        mask = 64'h0000_0000_FFFF_FFFF << {lo[2], 5'b00000};
        data = {32'h0, new_data[31:0]} << {lo[2], 5'b00000};
      end
      default: begin
        mask = 64'hFFFF_FFFF_FFFF_FFFF;
        data = new_data;
      end
    endcase
    return (old_dw & ~mask) | (data & mask);
  endfunction

`ifdef STORE_MISALIGN_TRAP_EN
  // Natural alignment check; bytes can never be misaligned.
  function automatic logic is_misaligned(
    input logic [1:0] st,
    input logic [2:0] lo
  );
    logic res;
    case (st)
      ST_SD:   res = (lo != 3'b000);
      ST_SW:   res = (lo[1:0] != 2'b00);
      ST_SH:   res = (lo[0] != 1'b0);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Misalignment of the incoming request (only meaningful in IDLE).
  always_comb begin
    trap_s = is_misaligned(store_type, addr[2:0]);
  end
`else
  // Trap disabled: every request proceeds to memory.
  always_comb begin
    trap_s = 1'b0;
  end
`endif

  // Next-state, operand capture and next-output computation.
  always_comb begin
    state_nxt_s     = state_r;
    addr_nxt_s      = addr_r;
    wdata_nxt_s     = wdata_r;
    type_nxt_s      = type_r;
    mem_wdata_nxt_s = mem_wdata_r;
    misalign_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          addr_nxt_s  = addr;
          wdata_nxt_s = wdata;
          type_nxt_s  = store_type;
          if (trap_s) begin
            state_nxt_s    = DONE;
            misalign_nxt_s = 1'b1;
          end else if (store_type == ST_SD) begin
            state_nxt_s     = WR;
            mem_wdata_nxt_s = wdata;
          end else begin
            state_nxt_s = RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        state_nxt_s = MERGE;
      end
      MERGE: begin
        mem_wdata_nxt_s = merge_lane(mem_rdata, wdata_r, type_r, addr_r[2:0]);
        state_nxt_s     = WR;
      end
      WR: begin
        state_nxt_s = DONE;
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    if (state_nxt_s != IDLE) begin
      mem_addr_nxt_s = {addr_nxt_s[63:3], 3'b000};
    end else begin
      mem_addr_nxt_s = 64'h0;
    end
  end

  // State, captured operands and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      addr_r      <= 64'h0;
      wdata_r     <= 64'h0;
      type_r      <= 2'b00;
      mem_addr_r  <= 64'h0;
      mem_wdata_r <= 64'h0;
      mem_wr_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      misalign_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      type_r      <= type_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      mem_wr_r    <= (state_nxt_s == WR);
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == DONE);
      misalign_r  <= misalign_nxt_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wr    = mem_wr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign misalign  = misalign_r;

endmodule

// File: tb/tb_store_merge.sv
`timescale 1ns/1ps

module tb_store_merge;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  store_type;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] mem_rdata;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        misalign;

  logic [63:0] mem_word;
  logic [63:0] exp_addr_q[$];
  logic [63:0] exp_data_q[$];
  int          checks;
  int          failures;
  int          wr_seen;
  int          saved_wr;

  store_merge dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .store_type (store_type),
    .addr       (addr),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr     (mem_wr),
    .busy       (busy),
    .done       (done),
    .misalign   (misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory holding the single doubleword under test.
  always @(posedge clk) begin
    mem_rdata <= mem_word;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed write is popped and compared.
  always @(negedge clk) begin
    if (mem_wr !== 1'b0) begin
      wr_seen++;
      if (exp_addr_q.size() == 0) begin
        check("unexpected_wr", {63'h0, mem_wr}, 64'h0);
      end else begin
        check("wr_addr", mem_addr, exp_addr_q.pop_front());
        check("wr_data", mem_wdata, exp_data_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] t, input logic [63:0] a, input logic [63:0] d);
    start      = 1'b1;
    store_type = t;
    addr       = a;
    wdata      = d;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    wr_seen    = 0;
    rst        = 1'b0;
    start      = 1'b0;
    store_type = 2'b00;
    addr       = 64'h0;
    wdata      = 64'h0;
    mem_word   = 64'h0;
    mem_rdata  = 64'h0;

    // Reset state
    @(negedge clk);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_mem_wr", {63'h0, mem_wr}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_misalign", {63'h0, misalign}, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    // sd straight write
    issue(2'b00, 64'h10, 64'h1122334455667788);
    exp_addr_q.push_back(64'h10);
    exp_data_q.push_back(64'h1122334455667788);
    @(negedge clk); start = 1'b0;
    check("sd_c1_wr", {63'h0, mem_wr}, 64'h1);
    check("sd_c1_addr", mem_addr, 64'h10);
    check("sd_c1_busy", {63'h0, busy}, 64'h1);
    check("sd_c1_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    check("sd_c2_done", {63'h0, done}, 64'h1);
    check("sd_c2_wr", {63'h0, mem_wr}, 64'h0);
    check("sd_c2_busy", {63'h0, busy}, 64'h1);
    @(negedge clk);
    check("sd_c3_busy", {63'h0, busy}, 64'h0);
    check("sd_c3_addr", mem_addr, 64'h0);

    // sb read-modify-write
    mem_word = 64'hFFFFFFFFFFFFFFFF;
    issue(2'b11, 64'h13, 64'hAB);
    exp_addr_q.push_back(64'h10);
    exp_data_q.push_back(64'hFFFFFFFFABFFFFFF);
    @(negedge clk); start = 1'b0;
    check("sb_c1_wr", {63'h0, mem_wr}, 64'h0);
    check("sb_c1_addr", mem_addr, 64'h10);
    @(negedge clk);
    check("sb_c2_wr", {63'h0, mem_wr}, 64'h0);
    @(negedge clk);
    check("sb_c3_wr", {63'h0, mem_wr}, 64'h1);
    @(negedge clk);
    check("sb_c4_done", {63'h0, done}, 64'h1);
    check("sb_c4_misalign", {63'h0, misalign}, 64'h0);
    @(negedge clk);
    check("sb_c5_busy", {63'h0, busy}, 64'h0);

    // sh with ignored start during MERGE, then back-to-back sd
    mem_word = 64'h0;
    issue(2'b10, 64'h16, 64'h1234BEEF);
    exp_addr_q.push_back(64'h10);
    exp_data_q.push_back(64'hBEEF000000000000);
    @(negedge clk); start = 1'b0;
    check("sh_c1_addr", mem_addr, 64'h10);
    @(negedge clk);
    issue(2'b00, 64'h28, 64'h5555);
    @(negedge clk); start = 1'b0;
    check("sh_c3_wr", {63'h0, mem_wr}, 64'h1);
    check("sh_c3_addr", mem_addr, 64'h10);
    @(negedge clk);
    check("sh_c4_done", {63'h0, done}, 64'h1);
    issue(2'b00, 64'h20, 64'hDEADBEEF01234567);
    exp_addr_q.push_back(64'h20);
    exp_data_q.push_back(64'hDEADBEEF01234567);
    @(negedge clk);
    check("b2b_idle_busy", {63'h0, busy}, 64'h0);
    check("b2b_idle_done", {63'h0, done}, 64'h0);
    @(negedge clk); start = 1'b0;
    check("b2b_c1_wr", {63'h0, mem_wr}, 64'h1);
    check("b2b_c1_addr", mem_addr, 64'h20);
    @(negedge clk);
    check("b2b_c2_done", {63'h0, done}, 64'h1);
    @(negedge clk);

    // Reset during MERGE of an sw aborts the store
    mem_word = 64'h0123456789ABCDEF;
    issue(2'b01, 64'h18, 64'h77);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    saved_wr = wr_seen;
    rst = 1'b0;
    #1;
    check("abort_mem_addr", mem_addr, 64'h0);
    check("abort_mem_wdata", mem_wdata, 64'h0);
    check("abort_mem_wr", {63'h0, mem_wr}, 64'h0);
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    check("abort_misalign", {63'h0, misalign}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_idle_busy", {63'h0, busy}, 64'h0);
    check("abort_idle_addr", mem_addr, 64'h0);
    check("abort_no_write", 64'(wr_seen), 64'(saved_wr));

    // sw at a half-aligned address
    mem_word = 64'h0;
    saved_wr = wr_seen;
    issue(2'b01, 64'h12, 64'hCAFEBABE);
`ifdef STORE_MISALIGN_TRAP_EN
    @(negedge clk); start = 1'b0;
    check("mis_c1_done", {63'h0, done}, 64'h1);
    check("mis_c1_misalign", {63'h0, misalign}, 64'h1);
    check("mis_c1_wr", {63'h0, mem_wr}, 64'h0);
    @(negedge clk);
    check("mis_c2_busy", {63'h0, busy}, 64'h0);
    check("mis_c2_misalign", {63'h0, misalign}, 64'h0);
    check("mis_no_write", 64'(wr_seen), 64'(saved_wr));
`else
    exp_addr_q.push_back(64'h10);
    exp_data_q.push_back(64'h00000000CAFEBABE);
    @(negedge clk); start = 1'b0;
    check("sw_c1_wr", {63'h0, mem_wr}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    check("sw_c3_wr", {63'h0, mem_wr}, 64'h1);
    @(negedge clk);
    check("sw_c4_done", {63'h0, done}, 64'h1);
    check("sw_c4_misalign", {63'h0, misalign}, 64'h0);
    check("sw_one_write", 64'(wr_seen), 64'(saved_wr + 1));
`endif
    @(negedge clk);
    @(negedge clk);

    check("sb_queue_empty", 64'(exp_addr_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
